psum_collector_conv2: RTL and testbench
=======================================

Name: psum_collector_conv2

Overview:
- Drain end of the conv-layer-2 PE row: consumes the 14-bit partial-sum stream leaving the last PE in the chain.
- Discards warm-up samples produced while the 3-tap ifmap shift register fills.
- Requantizes valid sums (ReLU, rounding right-shift, saturate to 8 bits).
- Buffers results in a small FIFO with a valid/ready interface toward the NICE writeback path.
- Paces upstream through a stall signal and reports frame completion.

Parameters:
PSUM_W, 14, width of incoming partial sum (signed)
OUT_W, 8, width of requantized output (unsigned)
IFMAP_W, 12, pixels per input row (en cycles per row)
IFMAP_H, 10, rows per frame
KERNEL, 3, taps per PE row; first KERNEL-1 samples of each row are invalid
SHIFT, 4, requantization right-shift (>=1)
FIFO_DEPTH, 8, output FIFO entries (power of 2)

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
en_in  in  1  same enable that drives the PE row; one pixel per en cycle
row_start  in  1  qualifies the first en_in cycle of a row (ignored without en_in)
psum_in  in  PSUM_W  Psum_out of last PE; valid the cycle after its en_in cycle
out_data  out  OUT_W  FIFO head
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head when out_valid&out_ready
stall_out  out  1  upstream must deassert en_in next cycle
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at frame end
overflow_err  out  1  sticky: a valid sample was dropped
clr_err  in  1  clears overflow_err

Behaviour:
Reset (rst=1 at posedge): all of the following are cleared.
- All outputs 0, FIFO empty, counters 0, state IDLE.
- Any in-flight sample is discarded.

Counters:
- col counts en_in cycles within a row, 0..IFMAP_W-1.
- row counts completed rows, 0..IFMAP_H-1.
- en_in with row_start loads col=0.

Sample pipeline:
- Register take_d = en_in & (col >= KERNEL-1), using col of that cycle.
- In the next cycle, when take_d=1, psum_in is requantized and pushed.
- Latency: en_in cycle t -> FIFO write at edge ending t+1 -> out_valid earliest t+2.

Requantization (at PSUM_W+1 bits):
- Negative psum gives 0.
- Otherwise r = (psum + 2^(SHIFT-1)) >> SHIFT.
- Saturate r to 2^OUT_W-1.

FSM:
- IDLE: en_in&row_start -> FILL (col=0). en_in without row_start is ignored.
- FILL: discard. When col reaches KERNEL-2 on en_in -> STREAM.
- STREAM: on en_in with col=IFMAP_W-1, end of row:
  - if row=IFMAP_H-1 -> DRAIN;
  - else row++ -> ROW_WAIT.
- ROW_WAIT: en_in&row_start -> FILL.
- DRAIN: wait until the last take_d sample is pushed and the FIFO is empty. Then pulse frame_done, row=0, -> IDLE.
- row_start&en_in in FILL or STREAM aborts the current row: row not incremented, col=0, -> FILL.
- en_in=0 holds all counters and state. Gaps between pixels are legal.

FIFO:
- Simultaneous push and pop are always legal, including when full; count is unchanged.
- Push when full without pop: sample dropped and overflow_err set.
- Pop when empty: no effect.
- stall_out = (count >= FIFO_DEPTH-2). This is registered-free and covers the one sample already in flight.

Error flag:
- overflow_err stays set until rst or clr_err.
- A simultaneous clr_err and new overflow leaves it set.

Output data:
- out_data holds its value while out_valid & !out_ready.
- out_data is 0 when the FIFO is empty.

Test Plan:
1. Reset then one row, out_ready=1:
   - Stimulus: 12 en_in cycles, row_start on the first, psum_in = 100 for every valid sample.
   - Required: exactly 10 pushes, each out_data=6 ((100+8)>>4).
   - Required: first out_valid 2 cycles after the en_in with col=2.
2. Arithmetic:
   - psum_in = -5 -> 0.
   - psum_in = 8191 -> 255 (saturated).
   - psum_in = 7 -> 0.
   - psum_in = 8 -> 1 (rounding boundary).
3. Full frame, 10 rows with 3-cycle en_in gaps, out_ready=1:
   - Required: 100 outputs, in order.
   - Required: single frame_done pulse after the last pop; busy falls with it.
4. Backpressure, out_ready=0, upstream obeying stall_out:
   - Required: stall_out rises at count=6.
   - Required: FIFO reaches 8 with no overflow_err.
   - Then out_ready=1 drains all samples, in order.
5. Forced overflow:
   - Stimulus: ignore stall_out with out_ready=0 while 10 valid samples arrive.
   - Required: 8 stored, overflow_err=1.
   - clr_err -> 0.
   - Push and pop together at full -> count stays 8, no error.
6. Disturbances:
   - row_start mid-row at col=5 -> row restarts, row count unchanged, 10 outputs follow.
   - rst asserted in STREAM with 4 entries queued -> next cycle out_valid=0, busy=0, all counters 0.

Source files
------------

// File: rtl/psum_collector_conv2.sv
// psum_collector_conv2
// Drain end of the conv-layer-2 PE row. Tracks pixel position within each
// row/frame, drops warm-up sums produced while the tap shift register fills,
// requantizes the remaining sums (ReLU, rounding shift, 8-bit saturate) and
// queues them in a small FIFO presented as a valid/ready stream.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | no frame in progress; waiting for en_in & row_start
// S_FILL     | tap register filling; sums of this row are discarded
// S_STREAM   | every en_in pixel yields a valid sum to requantize and queue
// S_ROW_WAIT | row finished, frame not; waiting for the next row_start
// S_DRAIN    | last row finished; waiting for in-flight sum and empty FIFO
module psum_collector_conv2 #(
  parameter int PSUM_W     = 14,
  parameter int OUT_W      = 8,
  parameter int IFMAP_W    = 12,
  parameter int IFMAP_H    = 10,
  parameter int KERNEL     = 3,
  parameter int SHIFT      = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_in,
  input  logic              row_start,
  input  logic [PSUM_W-1:0] psum_in,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              stall_out,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow_err,
  input  logic              clr_err
);

  localparam int COL_W = (IFMAP_W > 1) ? $clog2(IFMAP_W) : 1;
  localparam int ROW_W = (IFMAP_H > 1) ? $clog2(IFMAP_H) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [COL_W-1:0] COL_LAST        = COL_W'(IFMAP_W - 1);
  localparam logic [COL_W-1:0] COL_FILL_END    = COL_W'(KERNEL - 2);
  localparam logic [COL_W-1:0] COL_FIRST_VALID = COL_W'(KERNEL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST        = ROW_W'(IFMAP_H - 1);
  localparam logic [CNT_W-1:0] CNT_FULL        = CNT_W'(FIFO_DEPTH);
  // Two below full: one sum may already be in flight when upstream reacts.
  localparam logic [CNT_W-1:0] CNT_STALL       = CNT_W'(FIFO_DEPTH - 2);

  localparam logic [PSUM_W:0] ROUND_ADD = (PSUM_W + 1)'(2 ** (SHIFT - 1));
  localparam logic [PSUM_W:0] SAT_MAX   = (PSUM_W + 1)'(2 ** OUT_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_ROW_WAIT,
    S_DRAIN
  } state_t;

  // With a 2-tap row the row_start pixel already completes the fill.
  localparam state_t ROW_ENTRY = (KERNEL > 2) ? S_FILL : S_STREAM;

  state_t           state, state_nxt;
  logic [COL_W-1:0] col, col_nxt, cur_col;
  logic [ROW_W-1:0] row, row_nxt;
  logic             pix_en;
  logic             take, take_d;
  logic             frame_end;

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, full, wr_en, drop;

  logic [PSUM_W:0]  rnd_sum;
  logic [PSUM_W:0]  shifted;
  logic [OUT_W-1:0] q_data;

  // Next-state, position counters and sample qualification.
  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    pix_en    = 1'b0;
    frame_end = 1'b0;
    // A row_start pixel is column 0 regardless of where the row counter was.
    cur_col   = row_start ? '0 : col;

    case (state)
      S_IDLE, S_ROW_WAIT: begin
        if (en_in && row_start) begin
          pix_en    = 1'b1;
          state_nxt = ROW_ENTRY;
        end
      end
      S_FILL: begin
        if (en_in) begin
          pix_en = 1'b1;
          if (row_start) begin
            state_nxt = ROW_ENTRY;
          end else if (col == COL_FILL_END) begin
            state_nxt = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (en_in) begin
          pix_en = 1'b1;
          if (row_start) begin
            // Aborted row: restart it without counting it as completed.
            state_nxt = ROW_ENTRY;
          end else if (col == COL_LAST) begin
            if (row == ROW_LAST) begin
              state_nxt = S_DRAIN;
            end else begin
              row_nxt   = row + 1'b1;
              state_nxt = S_ROW_WAIT;
            end
          end
        end
      end
      S_DRAIN: begin
        if (!take_d && (count == '0)) begin
          frame_end = 1'b1;
          row_nxt   = '0;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (pix_en) begin
      col_nxt = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
    end

    take = pix_en && (cur_col >= COL_FIRST_VALID);
  end

  // State, counters, sample-valid pipeline and frame-done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      take_d     <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      take_d     <= take;
      frame_done <= frame_end;
    end
  end

  // Requantize: ReLU, round-half-up shift, saturate to the output width.
  always_comb begin
    rnd_sum = {1'b0, psum_in} + ROUND_ADD;
    shifted = rnd_sum >> SHIFT;
    q_data  = '0;
    if (!psum_in[PSUM_W-1]) begin
      if (shifted > SAT_MAX) begin
        q_data = SAT_MAX[OUT_W-1:0];
      end else begin
        q_data = shifted[OUT_W-1:0];
      end
    end
  end

  assign push      = take_d;
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign full      = (count == CNT_FULL);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr_en     = push && (!full || pop);
  assign drop      = push && full && !pop;

  // FIFO storage; contents need no reset because out_data is masked when empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= q_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_err <= 1'b0;
    end else if (drop) begin
      overflow_err <= 1'b1;
    end else if (clr_err) begin
      overflow_err <= 1'b0;
    end
  end

  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign stall_out = (count >= CNT_STALL);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_psum_collector_conv2.sv
// Bench for psum_collector_conv2: directed rows/frames, with a scoreboard
// queue filled at stimulus time and drained by an output monitor.
module tb_psum_collector_conv2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_in = 1'b0;
  logic        row_start = 1'b0;
  logic [13:0] psum_in = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        stall_out;
  logic        busy;
  logic        frame_done;
  logic        overflow_err;
  logic        clr_err = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  int          fd_cnt = 0;
  logic [7:0]  sb[$];
  logic [13:0] pend = '0;
  logic        stall_q = 1'b0;

  localparam logic [13:0] T2_IN [10] = '{14'h3FFB, 14'd8191, 14'd7, 14'd8, 14'd100,
                                         14'd0, 14'd15, 14'd16, 14'd4088, 14'h2000};
  localparam logic [7:0]  T2_EXP [10] = '{8'd0, 8'd255, 8'd0, 8'd1, 8'd6,
                                          8'd0, 8'd1, 8'd1, 8'd255, 8'd0};

  always #5 clk = ~clk;

  psum_collector_conv2 dut (
    .clk          (clk),
    .rst          (rst),
    .en_in        (en_in),
    .row_start    (row_start),
    .psum_in      (psum_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .stall_out    (stall_out),
    .busy         (busy),
    .frame_done   (frame_done),
    .overflow_err (overflow_err),
    .clr_err      (clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One clock of stimulus; v is the sum for this pixel, presented next cycle.
  task automatic cyc(input logic en, input logic rs, input logic [13:0] v);
    en_in     = en;
    row_start = rs;
    psum_in   = pend;
    pend      = v;
    @(negedge clk);
    stall_q = stall_out;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    pend = '0;
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      cyc(1'b0, 1'b0, '0);
      n++;
    end
    check(name, (sb.size() == 0) && !out_valid, 1);
  endtask

  // Output monitor: every accepted beat is compared against the scoreboard.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (out_valid && out_ready) begin
        pops++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0d expected=none", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, f0, k, idx, guard, n;
    logic seen6, seen8, found, busy_prev;
    logic [13:0] v;

    @(posedge clk);
    #1;

    // 1: reset state, then one row of 100s
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall_out, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow_err, 0);
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2) sb.push_back(8'd6);
      cyc(1'b1, i == 0, 14'd100);
      if (i == 2) check("t1_latency_early", out_valid, 0);
      if (i == 3) check("t1_latency_first", out_valid, 1);
    end
    wait_drain("t1_drain", 20);
    check("t1_pushes", pops - p0, 10);
    check("t1_row_wait_busy", busy, 1);
    check("t1_row_count", dut.row, 1);

    // 2: arithmetic corners on the next row
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2) sb.push_back(T2_EXP[i-2]);
      cyc(1'b1, i == 0, (i >= 2) ? T2_IN[i-2] : 14'h3FFF);
    end
    wait_drain("t2_drain", 20);
    check("t2_pushes", pops - p0, 10);

    // 3: full frame with gaps
    do_reset();
    out_ready = 1'b1;
    p0 = pops;
    f0 = fd_cnt;
    k = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 12; c++) begin
        v = '0;
        if (c >= 2) begin
          v = 14'(16 * k);
          sb.push_back(k[7:0]);
          k++;
        end
        cyc(1'b1, c == 0, v);
        if (!(r == 9 && c == 11)) begin
          repeat (3) cyc(1'b0, 1'b0, '0);
        end
      end
    end
    n = 0;
    found = 1'b0;
    busy_prev = 1'b0;
    while (!found && n < 50) begin
      busy_prev = busy;
      cyc(1'b0, 1'b0, '0);
      n++;
      if (frame_done) found = 1'b1;
    end
    check("t3_frame_done_seen", found, 1);
    check("t3_busy_fall", busy, 0);
    check("t3_busy_before", busy_prev, 1);
    check("t3_sb_empty_at_done", sb.size(), 0);
    check("t3_outputs", pops - p0, 100);
    cyc(1'b0, 1'b0, '0);
    check("t3_pulse_width", frame_done, 0);
    check("t3_pulses", fd_cnt - f0, 1);

    // 4: backpressure with upstream obeying stall_out
    do_reset();
    out_ready = 1'b0;
    p0 = pops;
    idx = 0;
    guard = 0;
    seen6 = 1'b0;
    seen8 = 1'b0;
    while (idx < 12 && guard < 300) begin
      guard++;
      if (stall_q) begin
        cyc(1'b0, 1'b0, '0);
      end else begin
        if (idx >= 2) sb.push_back(8'(idx + 20));
        cyc(1'b1, idx == 0, 14'(16 * (idx + 20)));
        idx++;
      end
      if (!seen6 && stall_out) begin
        seen6 = 1'b1;
        check("t4_stall_at_6", dut.count, 6);
      end
      if (seen6 && !seen8 && dut.count == 8) begin
        seen8 = 1'b1;
        check("t4_no_overflow_at_8", overflow_err, 0);
        check("t4_stall_at_full", stall_out, 1);
        out_ready = 1'b1;
      end
    end
    check("t4_stall_seen", seen6, 1);
    check("t4_reached_full", seen8, 1);
    wait_drain("t4_drain", 30);
    check("t4_outputs", pops - p0, 10);
    check("t4_overflow_end", overflow_err, 0);

    // 5: forced overflow, clear, push+pop at full
    do_reset();
    out_ready = 1'b0;
    p0 = pops;
    for (int i = 0; i < 12; i++) begin
      if (i >= 2 && i <= 9) sb.push_back(8'(i - 1));
      cyc(1'b1, i == 0, (i >= 2) ? 14'(16 * (i - 1)) : 14'd0);
    end
    repeat (2) cyc(1'b0, 1'b0, '0);
    check("t5_count_full", dut.count, 8);
    check("t5_overflow_set", overflow_err, 1);
    check("t5_head_held", out_data, 1);
    clr_err = 1'b1;
    cyc(1'b0, 1'b0, '0);
    clr_err = 1'b0;
    check("t5_overflow_clr", overflow_err, 0);
    cyc(1'b1, 1'b1, '0);
    cyc(1'b1, 1'b0, '0);
    sb.push_back(8'd9);
    cyc(1'b1, 1'b0, 14'd144);
    out_ready = 1'b1;
    cyc(1'b0, 1'b0, '0);
    out_ready = 1'b0;
    check("t5_pushpop_count", dut.count, 8);
    check("t5_pushpop_no_err", overflow_err, 0);
    out_ready = 1'b1;
    wait_drain("t5_drain", 30);
    check("t5_outputs", pops - p0, 9);
    check("t5_overflow_end", overflow_err, 0);

    // 6a: row_start at col 5 restarts the row
    do_reset();
    out_ready = 1'b1;
    p0 = pops;
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) sb.push_back(8'(40 + c));
      cyc(1'b1, c == 0, 14'(16 * (40 + c)));
    end
    cyc(1'b1, 1'b1, '0);
    check("t6_abort_row", dut.row, 0);
    check("t6_abort_col", dut.col, 1);
    for (int c = 1; c < 12; c++) begin
      if (c >= 2) sb.push_back(8'(50 + c));
      cyc(1'b1, 1'b0, 14'(16 * (50 + c)));
    end
    wait_drain("t6_drain", 20);
    check("t6_outputs", pops - p0, 13);
    check("t6_row_after", dut.row, 1);

    // 6b: reset in STREAM with 4 queued and one sum in flight
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      cyc(1'b1, c == 0, 14'd320);
    end
    check("t6_queued", dut.count, 4);
    rst = 1'b1;
    cyc(1'b0, 1'b0, '0);
    rst = 1'b0;
    sb.delete();
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_count", dut.count, 0);
    check("t6_rst_col", dut.col, 0);
    check("t6_rst_row", dut.row, 0);
    check("t6_rst_out_data", out_data, 0);
    check("t6_rst_stall", stall_out, 0);
    cyc(1'b0, 1'b0, '0);
    check("t6_inflight_dropped", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
